parity_generator: RTL and testbench
===================================

PARITY_GENERATOR -- requirements
Module: parity_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the tdata buses in bits.
REQ-002 Parameter ODD_PARITY, default 0: 0 selects even column parity, 1 selects odd.
REQ-003 Port inclock  input  1: single clock; all logic is on its rising edge.
REQ-004 Port inreset_n  input  1: reset, asynchronous assert and active-low.
REQ-005 Port axis_s_tvalid  input  1: upstream beat valid.
REQ-006 Port axis_s_tdata  input  DATA_WIDTH: upstream payload word.
REQ-007 Port axis_s_tlast  input  1: marks the final payload word of a packet.
REQ-008 Port axis_s_tready  output  1: block accepts an upstream beat.
REQ-009 Port axis_m_tvalid  output  1: downstream beat valid; feeds parity_tester.
REQ-010 Port axis_m_tdata  output  DATA_WIDTH: payload word or parity trailer.
REQ-011 Port axis_m_tlast  output  1: asserted only on the trailer beat.
REQ-012 Port axis_m_tready  input  1: downstream accepts a beat.
REQ-013 Port pkt_count  output  16: count of trailers emitted.

Function
REQ-014 A beat transfers on any interface when tvalid and tready are both 1 at a rising edge.
REQ-015 Each input packet of N words produces N+1 output beats: the N words unchanged, with tlast=0, then one trailer word with tlast=1.
REQ-016 The trailer word is the bitwise XOR of all N payload words, XORed with all-ones when ODD_PARITY=1.
REQ-017 The FSM has two states: PASS (reset state) and TRAILER.
REQ-018 axis_s_tready is 1 exactly when state=PASS and (axis_m_tvalid=0 or axis_m_tready=1); it has no dependence on axis_s_tvalid.
REQ-019 In PASS, an accepted beat loads the output register on that edge (1-cycle latency) and XORs its data into accumulator acc.
REQ-020 An accepted beat with axis_s_tlast=1 moves the FSM to TRAILER.
REQ-021 In TRAILER, when the output slot is free (axis_m_tvalid=0 or axis_m_tready=1), the trailer loads into the output register; on the same edge acc clears to 0, pkt_count increments and the FSM returns to PASS.
REQ-022 Input is stalled for at least one cycle per packet (while in TRAILER); at all other times throughput is one beat per cycle under continuous tready.
REQ-023 While axis_m_tvalid=1 and axis_m_tready=0, axis_m_tdata, axis_m_tlast and axis_m_tvalid hold stable.
REQ-024 axis_m_tvalid deasserts on an edge where the slot drains and no new beat or trailer loads.
REQ-025 A single-word packet emits that word followed by a trailer equal to the word (even parity) or its complement (odd parity).
REQ-026 pkt_count wraps from 0xFFFF to 0x0000.
REQ-027 Upstream beats are not dropped or duplicated; a beat offered with axis_s_tready=0 is simply not taken.

Reset
REQ-028 While inreset_n=0: axis_m_tvalid=0, axis_m_tdata=0, axis_m_tlast=0, acc=0, pkt_count=0, state=PASS, and axis_s_tready=0.
REQ-029 Reset mid-packet discards the partial packet; no trailer is emitted for it, and the first beat after release starts a new packet.
REQ-030 axis_s_tready may first assert on the first rising edge after inreset_n deasserts.

Structure
REQ-031 Package parity_pkg holds the FSM state enum (PASS, TRAILER) and the pkt_count width constant (16); parity_tester shares the package.
REQ-032 The output register slice (valid, data and last register with hold logic) is a sub-module named axis_out_reg; the FSM, accumulator and counter stay in parity_generator.

Verification
REQ-033 With DATA_WIDTH=8, even parity, and axis_m_tready held at 1: input 0x12, 0x34, 0x56 (last) -> output 0x12, 0x34, 0x56 (tlast=0), then 0x70 (tlast=1), and pkt_count=1.
REQ-034 With ODD_PARITY=1: the same packet -> trailer 0x8F.
REQ-035 Single-beat packet 0xA5 (even) -> outputs 0xA5 then 0xA5 with tlast=1; a back-to-back second packet is stalled exactly one cycle.
REQ-036 With axis_m_tready toggling in the pattern 1,0,0,1 during a 4-word packet -> output data is held stable while stalled, no beats are lost, the trailer is correct, and axis_s_tready=0 whenever the output is stalled.
REQ-037 Assert inreset_n=0 after 2 of 3 words are accepted -> axis_m_tvalid=0 immediately; after release, packet 0x01 (last) -> trailer 0x01 and pkt_count=1.
REQ-038 Preload pkt_count to 0xFFFF by forcing it or by sending 65535 packets; one more packet -> pkt_count=0x0000.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type and counter width for the parity generator/tester pair
package parity_pkg;
    typedef enum logic {PASS = 1'b0, TRAILER = 1'b1} state_t;
    localparam int PKT_CNT_W = 16;
endpackage

// File: rtl/parity_generator_if.sv
// parity_generator_if: AXI-Stream upstream and downstream channels of the parity generator
interface parity_generator_if #(parameter int DATA_WIDTH = 8);
    logic                  axis_s_tvalid;
    logic [DATA_WIDTH-1:0] axis_s_tdata;
    logic                  axis_s_tlast;
    logic                  axis_s_tready;
    logic                  axis_m_tvalid;
    logic [DATA_WIDTH-1:0] axis_m_tdata;
    logic                  axis_m_tlast;
    logic                  axis_m_tready;
    modport slave (
        input  axis_s_tvalid, axis_s_tdata, axis_s_tlast,
        output axis_s_tready,
        output axis_m_tvalid, axis_m_tdata, axis_m_tlast,
        input  axis_m_tready
    );
    modport master (
        output axis_s_tvalid, axis_s_tdata, axis_s_tlast,
        input  axis_s_tready,
        input  axis_m_tvalid, axis_m_tdata, axis_m_tlast,
        output axis_m_tready
    );
endinterface

// File: rtl/parity_generator_axis_out_reg.sv
// axis_out_reg: single-entry output register slice that holds its beat until downstream takes it
module axis_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  inclock,
    input  logic                  inreset_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    // load a new beat when offered, otherwise drop valid once the held beat drains
    always_ff @(posedge inclock or negedge inreset_n) begin
        if (!inreset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
endmodule

// File: rtl/parity_generator.sv
// parity_generator: passes packets through and appends a column-parity trailer word to each
module parity_generator
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 inclock,
    input  logic                 inreset_n,
    parity_generator_if.slave    bus,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_run;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [PKT_CNT_W-1:0]  r_pkt_count;
    logic                  w_m_valid;
    logic [DATA_WIDTH-1:0] w_m_data;
    logic                  w_m_last;
    logic                  w_slot_free;
    logic                  w_s_ready;
    logic                  w_s_fire;
    logic                  w_trl_fire;
    logic                  w_load;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_data;

    // handshake decode, output-slot muxing and FSM next state
    always_comb begin
        w_slot_free = !w_m_valid || bus.axis_m_tready;
        w_s_ready   = r_run && (r_state == PASS) && w_slot_free;
        w_s_fire    = w_s_ready && bus.axis_s_tvalid;
        w_trl_fire  = (r_state == TRAILER) && w_slot_free;
        w_load      = w_s_fire || w_trl_fire;
        w_last      = w_trl_fire;
        w_data      = w_trl_fire ? (r_acc ^ {DATA_WIDTH{ODD_PARITY}}) : bus.axis_s_tdata;
        w_state_nxt = r_state;
        if (w_s_fire && bus.axis_s_tlast)
            w_state_nxt = TRAILER;
        else if (w_trl_fire)
            w_state_nxt = PASS;
    end

    // FSM state register
    always_ff @(posedge inclock or negedge inreset_n) begin
        if (!inreset_n)
            r_state <= PASS;
        else
            r_state <= w_state_nxt;
    end

    // keeps s_tready low throughout reset; opens on the first edge after release
    always_ff @(posedge inclock or negedge inreset_n) begin
        if (!inreset_n)
            r_run <= 1'b0;
        else
            r_run <= 1'b1;
    end

    // accumulate payload parity; the trailer load clears it and counts the packet
    always_ff @(posedge inclock or negedge inreset_n) begin
        if (!inreset_n) begin
            r_acc       <= '0;
            r_pkt_count <= '0;
        end else if (w_trl_fire) begin
            r_acc       <= '0;
            r_pkt_count <= r_pkt_count + 1'b1;
        end else if (w_s_fire) begin
            r_acc       <= r_acc ^ bus.axis_s_tdata;
        end
    end

    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
        .inclock   (inclock),
        .inreset_n (inreset_n),
        .i_load    (w_load),
        .i_data    (w_data),
        .i_last    (w_last),
        .i_ready   (bus.axis_m_tready),
        .o_valid   (w_m_valid),
        .o_data    (w_m_data),
        .o_last    (w_m_last)
    );

    assign bus.axis_s_tready = w_s_ready;
    assign bus.axis_m_tvalid = w_m_valid;
    assign bus.axis_m_tdata  = w_m_data;
    assign bus.axis_m_tlast  = w_m_last;
    assign pkt_count         = r_pkt_count;
endmodule

// File: tb/tb_parity_generator.sv
// tb_parity_generator: random and directed stimulus against a packet-level parity model
module tb_parity_generator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parity_generator_if #(.DATA_WIDTH(8)) tif ();
    parity_generator_if #(.DATA_WIDTH(8)) tio ();
    logic [15:0] cnt_e, cnt_o;

    assign tio.axis_s_tvalid = tif.axis_s_tvalid;
    assign tio.axis_s_tdata  = tif.axis_s_tdata;
    assign tio.axis_s_tlast  = tif.axis_s_tlast;
    assign tio.axis_m_tready = tif.axis_m_tready;

    parity_generator #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) dut_e (
        .inclock(clk), .inreset_n(rst_n), .bus(tif), .pkt_count(cnt_e));
    parity_generator #(.DATA_WIDTH(8), .ODD_PARITY(1'b1)) dut_o (
        .inclock(clk), .inreset_n(rst_n), .bus(tio), .pkt_count(cnt_o));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] exp_q [2][$];
    logic [8:0] log_q [2][$];
    logic [7:0] pkt_words [$];
    int acc_cyc [$];
    logic [15:0] exp_cnt [2];
    bit owe = 0;
    bit prev_stall [2];
    logic [8:0] prev_beat [2];
    int rdy_mode = 0;
    logic rdy_pat [$];
    logic mv [2], ml [2], sr [2];
    logic [7:0] md [2];
    logic [15:0] pc [2];
    logic [8:0] e;
    logic [7:0] t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // downstream ready source: steady, random or a scripted pattern
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1)
            tif.axis_m_tready = ($urandom_range(0, 9) < 7);
        else if (rdy_mode == 2 && rdy_pat.size() != 0)
            tif.axis_m_tready = rdy_pat.pop_front();
        else
            tif.axis_m_tready = 1'b1;
    end

    // monitor + model: every beat, hold rule and stall rule checked at mid-cycle
    always @(negedge clk) begin
        cyc++;
        mv[0] = tif.axis_m_tvalid; ml[0] = tif.axis_m_tlast; md[0] = tif.axis_m_tdata; sr[0] = tif.axis_s_tready; pc[0] = cnt_e;
        mv[1] = tio.axis_m_tvalid; ml[1] = tio.axis_m_tlast; md[1] = tio.axis_m_tdata; sr[1] = tio.axis_s_tready; pc[1] = cnt_o;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                exp_q[k].delete();
                prev_stall[k] = 0;
                exp_cnt[k] = '0;
            end
            pkt_words.delete();
            owe = 0;
        end else begin
            chk("s_tready_even_vs_odd", {31'd0, sr[1]}, {31'd0, sr[0]});
            for (int k = 0; k < 2; k++) begin
                if (prev_stall[k])
                    chk("hold_stable", {22'd0, mv[k], ml[k], md[k]}, {22'd0, 1'b1, prev_beat[k]});
                if (mv[k] && !tif.axis_m_tready)
                    chk("s_tready_while_stalled", {31'd0, sr[k]}, 32'd0);
                if (mv[k] && tif.axis_m_tready) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat got %h want none (t=%0t)", {ml[k], md[k]}, $time);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk("out_beat", {23'd0, ml[k], md[k]}, {23'd0, e});
                    end
                    log_q[k].push_back({ml[k], md[k]});
                    if (ml[k]) begin
                        exp_cnt[k] = exp_cnt[k] + 16'd1;
                        chk("pkt_count_at_trailer", {16'd0, pc[k]}, {16'd0, exp_cnt[k]});
                    end
                end
                prev_stall[k] = mv[k] && !tif.axis_m_tready;
                prev_beat[k] = {ml[k], md[k]};
            end
            if (owe) begin
                if (mv[0] && ml[0]) owe = 0;
                else chk("s_tready_trailer_owed", {31'd0, sr[0]}, 32'd0);
            end
            if (tif.axis_s_tvalid && sr[0]) begin
                acc_cyc.push_back(cyc);
                pkt_words.push_back(tif.axis_s_tdata);
                exp_q[0].push_back({1'b0, tif.axis_s_tdata});
                exp_q[1].push_back({1'b0, tif.axis_s_tdata});
                if (tif.axis_s_tlast) begin
                    t = '0;
                    foreach (pkt_words[i]) t = t ^ pkt_words[i];
                    exp_q[0].push_back({1'b1, t});
                    exp_q[1].push_back({1'b1, ~t});
                    pkt_words.delete();
                    owe = 1;
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input logic l);
        int n;
        tif.axis_s_tvalid = 1'b1;
        tif.axis_s_tdata = d;
        tif.axis_s_tlast = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tif.axis_s_tready && n < 300);
        if (!tif.axis_s_tready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got tready=0 want 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        tif.axis_s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q[0].size() != 0 || tif.axis_m_tvalid || owe) && n < 500);
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d queued want 0", exp_q[0].size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_q[0].delete();
        log_q[1].delete();
        acc_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, gap;
        tif.axis_s_tvalid = 1'b0;
        tif.axis_s_tdata = '0;
        tif.axis_s_tlast = 1'b0;
        tif.axis_m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", {31'd0, tif.axis_m_tvalid}, 0);
        chk("rst_m_tdata", {24'd0, tif.axis_m_tdata}, 0);
        chk("rst_m_tlast", {31'd0, tif.axis_m_tlast}, 0);
        chk("rst_s_tready", {31'd0, tif.axis_s_tready}, 0);
        chk("rst_pkt_count", {16'd0, cnt_e}, 0);
        chk("rst_odd_m_tvalid", {31'd0, tio.axis_m_tvalid}, 0);
        chk("rst_odd_s_tready", {31'd0, tio.axis_s_tready}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_tready_after_release", {31'd0, tif.axis_s_tready}, 1);

        clear_logs();
        send_word(8'h12, 0);
        send_word(8'h34, 0);
        send_word(8'h56, 1);
        drain();
        chk("p1_w0", {23'd0, log_q[0][0]}, 9'h012);
        chk("p1_w1", {23'd0, log_q[0][1]}, 9'h034);
        chk("p1_w2", {23'd0, log_q[0][2]}, 9'h056);
        chk("p1_trailer_even", {23'd0, log_q[0][3]}, 9'h170);
        chk("p1_trailer_odd", {23'd0, log_q[1][3]}, 9'h18F);
        chk("p1_pkt_count", {16'd0, cnt_e}, 1);
        chk("p1_throughput", acc_cyc[2] - acc_cyc[0], 2);

        clear_logs();
        send_word(8'hA5, 1);
        send_word(8'h3C, 1);
        drain();
        chk("single_word", {23'd0, log_q[0][0]}, 9'h0A5);
        chk("single_trailer_even", {23'd0, log_q[0][1]}, 9'h1A5);
        chk("single_trailer_odd", {23'd0, log_q[1][1]}, 9'h15A);
        chk("b2b_stall_one_cycle", acc_cyc[1] - acc_cyc[0], 2);
        chk("b2b_pkt_count", {16'd0, cnt_e}, 3);

        clear_logs();
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rdy_mode = 2;
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        send_word(8'h44, 0);
        send_word(8'h88, 1);
        drain();
        rdy_mode = 0;
        chk("stall_beats", log_q[0].size(), 5);
        chk("stall_trailer", {23'd0, log_q[0][4]}, 9'h1FF);
        chk("stall_pkt_count", {16'd0, cnt_e}, 4);

        rdy_mode = 1;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 5);
            for (int w = 0; w < len; w++) begin
                send_word(8'($urandom), w == len - 1);
                gap = $urandom_range(0, 3);
                if (gap > 1) begin
                    repeat (gap - 1) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end
        drain();
        rdy_mode = 0;
        chk("rand_pkt_count_even", {16'd0, cnt_e}, 29);
        chk("rand_pkt_count_odd", {16'd0, cnt_o}, 29);

        clear_logs();
        send_word(8'hAA, 0);
        send_word(8'hBB, 0);
        rst_n = 1'b0;
        #1;
        chk("midpkt_rst_m_tvalid", {31'd0, tif.axis_m_tvalid}, 0);
        chk("midpkt_rst_s_tready", {31'd0, tif.axis_s_tready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        send_word(8'h01, 1);
        drain();
        chk("post_rst_beats", log_q[0].size(), 2);
        chk("post_rst_word", {23'd0, log_q[0][0]}, 9'h001);
        chk("post_rst_trailer", {23'd0, log_q[0][1]}, 9'h101);
        chk("post_rst_pkt_count", {16'd0, cnt_e}, 1);

        force dut_e.r_pkt_count = 16'hFFFF;
        exp_cnt[0] = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_e.r_pkt_count;
        chk("preload_pkt_count", {16'd0, cnt_e}, 32'h0000FFFF);
        send_word(8'h5A, 1);
        drain();
        chk("wrap_pkt_count", {16'd0, cnt_e}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
